// File: rtl/rv_pe_pkg.sv
// Shared parameters and types for the RISC-V PE register-file write-back path.
package rv_pe_pkg;
  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int AW         = 5;
  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO; push is ignored when full, pop when empty.
module wb_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage carries no reset: an entry is only visible once counted.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: rtl/regfile_wb.sv
// Register-file write-back stage: buffered write-back, cfg-priority commit,
// per-register busy scoreboard and two combinational read ports.
module regfile_wb
  import rv_pe_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [XLEN-1:0] cfg_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_busy,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_busy,
  output logic [AW-1:0]   fifo_level
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Handshake: a request transfers on any rising edge where wb_valid && wb_ready;
  // the producer holds wb_addr/wb_data while wb_valid && !wb_ready.
  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  wb_req_t         w_wb_req;
  wb_req_t         w_head;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic            w_push;
  logic            w_pop;
  logic            w_issue;

  assign w_wb_req = '{addr: wb_addr, data: wb_data};
  assign wb_ready = rst_n && !w_full;
  assign w_push   = wb_valid && wb_ready;
  assign w_pop    = !w_empty && !cfg_we;

  wb_fifo #(
    .W     ($bits(wb_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_wb_req),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign fifo_level = AW'(w_count);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (cfg_we) begin
      if (cfg_addr != '0) r_regs[cfg_addr] <= cfg_data;
    end else if (w_pop && (w_head.addr != '0)) begin
      r_regs[w_head.addr] <= w_head.data;
    end
  end

  assign iss_ready = !r_busy[iss_rd];
  assign w_issue   = iss_valid && iss_ready && (iss_rd != '0);

  // Issue is applied after the commit clear so a same-edge set on that rd wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      if (w_pop)   r_busy[w_head.addr] <= 1'b0;
      if (w_issue) r_busy[iss_rd]      <= 1'b1;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : r_regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : r_regs[rs2_addr];
  assign rs1_busy = r_busy[rs1_addr];
  assign rs2_busy = r_busy[rs2_addr];
endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed scenarios plus randomized traffic against a
// queue/array reference model of the write-back stage.
module tb_regfile_wb;
  import rv_pe_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [XLEN-1:0] cfg_data;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            iss_ready;
  logic [AW-1:0]   rs1_addr;
  logic [XLEN-1:0] rs1_data;
  logic            rs1_busy;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs2_data;
  logic            rs2_busy;
  logic [AW-1:0]   fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  wb_req_t         m_q[$];

  regfile_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_ready  (iss_ready),
    .rs1_addr   (rs1_addr),
    .rs1_data   (rs1_data),
    .rs1_busy   (rs1_busy),
    .rs2_addr   (rs2_addr),
    .rs2_data   (rs2_data),
    .rs2_busy   (rs2_busy),
    .fifo_level (fifo_level)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the reference model across one edge using the inputs now applied.
  task automatic model_edge();
    bit      push;
    bit      pop;
    bit      iss_ok;
    wb_req_t h;
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_q.delete();
      return;
    end
    push   = wb_valid && (m_q.size() < FIFO_DEPTH);
    pop    = (m_q.size() > 0) && !cfg_we;
    iss_ok = iss_valid && (iss_rd != 0) && !m_busy[iss_rd];
    if (cfg_we && cfg_addr != 0) m_regs[cfg_addr] = cfg_data;
    if (pop) begin
      h = m_q.pop_front();
      if (h.addr != 0) m_regs[h.addr] = h.data;
      m_busy[h.addr] = 1'b0;
    end
    if (iss_ok) m_busy[iss_rd] = 1'b1;
    if (push) m_q.push_back('{addr: wb_addr, data: wb_data});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    #1;
    n_checks++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wb_ready_low got=%b exp=0", wb_ready); end
    tick();
    tick();
    rst_n = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd0; iss_rd = 5'd5;
    #1;
    n_checks++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs1_data got=%h exp=0", rs1_data); end
    n_checks++; if (rs2_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs2_data got=%h exp=0", rs2_data); end
    n_checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b%b exp=00", rs1_busy, rs2_busy); end
    n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb_ready got=%b exp=1", wb_ready); end
    n_checks++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_iss_ready got=%b exp=1", iss_ready); end
  endtask

  task automatic test_basic_write();
    iss_valid = 1'b1; iss_rd = 5'd5; rs1_addr = 5'd5;
    #1;
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL basic_iss_ready got=%b exp=1", iss_ready); end
    tick();
    iss_valid = 1'b0;
    #1;
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_set got=%b exp=1", rs1_busy); end
    n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL basic_iss_blocked got=%b exp=0", iss_ready); end
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_valid = 1'b0;
    #1;
    n_checks++; if (rs1_busy !== 1'b1 || rs1_data !== 32'h0) begin n_fail++; $display("FAIL basic_before_commit got=%b/%h exp=1/0", rs1_busy, rs1_data); end
    n_checks++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL basic_level got=%0d exp=1", fifo_level); end
    tick();
    n_checks++; if (rs1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_commit_data got=%h exp=deadbeef", rs1_data); end
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_clear got=%b exp=0", rs1_busy); end
    n_checks++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL basic_level_empty got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_cfg_priority();
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h11;
    tick();
    wb_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 5'd9; cfg_data = 32'h22;
    rs1_addr = 5'd9; rs2_addr = 5'd7;
    tick();
    n_checks++; if (rs1_data !== 32'h22) begin n_fail++; $display("FAIL cfg_x9 got=%h exp=22", rs1_data); end
    n_checks++; if (rs2_data !== 32'h0 || fifo_level !== 5'd1) begin n_fail++; $display("FAIL cfg_stall1 got=%h/%0d exp=0/1", rs2_data, fifo_level); end
    tick();
    n_checks++; if (rs2_data !== 32'h0 || fifo_level !== 5'd1) begin n_fail++; $display("FAIL cfg_stall2 got=%h/%0d exp=0/1", rs2_data, fifo_level); end
    cfg_we = 1'b0;
    tick();
    n_checks++; if (rs2_data !== 32'h11 || fifo_level !== 5'd0) begin n_fail++; $display("FAIL cfg_drain got=%h/%0d exp=11/0", rs2_data, fifo_level); end
  endtask

  task automatic test_full();
    cfg_we = 1'b1; cfg_addr = 5'd10; cfg_data = 32'hA5A5;
    wb_valid = 1'b1; wb_addr = 5'd20; wb_data = 32'h100;
    tick();
    wb_addr = 5'd21; wb_data = 32'h101;
    tick();
    wb_addr = 5'd22; wb_data = 32'h102;
    #1;
    n_checks++; if (wb_ready !== 1'b0 || fifo_level !== 5'd2) begin n_fail++; $display("FAIL full_ready got=%b/%0d exp=0/2", wb_ready, fifo_level); end
    tick();
    n_checks++; if (wb_ready !== 1'b0 || fifo_level !== 5'd2) begin n_fail++; $display("FAIL full_hold got=%b/%0d exp=0/2", wb_ready, fifo_level); end
    cfg_we = 1'b0;
    #1;
    n_checks++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_no_pop_path got=%b exp=0", wb_ready); end
    tick();
    n_checks++; if (wb_ready !== 1'b1 || fifo_level !== 5'd1) begin n_fail++; $display("FAIL full_freed got=%b/%0d exp=1/1", wb_ready, fifo_level); end
    tick();
    n_checks++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL full_push_pop got=%0d exp=1", fifo_level); end
    wb_valid = 1'b0;
    tick();
    rs1_addr = 5'd22; rs2_addr = 5'd10;
    #1;
    n_checks++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL full_empty got=%0d exp=0", fifo_level); end
    n_checks++; if (rs1_data !== 32'h102) begin n_fail++; $display("FAIL full_third got=%h exp=102", rs1_data); end
    n_checks++; if (rs2_data !== 32'hA5A5) begin n_fail++; $display("FAIL full_cfg got=%h exp=a5a5", rs2_data); end
  endtask

  task automatic test_x0();
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL x0_iss_ready got=%b exp=1", iss_ready); end
    tick();
    iss_valid = 1'b0; rs2_addr = 5'd0;
    #1;
    n_checks++; if (rs2_busy !== 1'b0 || iss_ready !== 1'b1) begin n_fail++; $display("FAIL x0_busy got=%b/%b exp=0/1", rs2_busy, iss_ready); end
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    tick();
    wb_valid = 1'b0;
    #1;
    n_checks++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL x0_level1 got=%0d exp=1", fifo_level); end
    tick();
    rs1_addr = 5'd0;
    #1;
    n_checks++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL x0_popped got=%0d exp=0", fifo_level); end
    n_checks++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL x0_read got=%h exp=0", rs1_data); end
  endtask

  task automatic test_same_edge();
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    tick();
    wb_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd3;
    #1;
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL same_iss_ready got=%b exp=1", iss_ready); end
    tick();
    iss_valid = 1'b0; rs1_addr = 5'd3;
    #1;
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL same_set_wins got=%b exp=1", rs1_busy); end
    n_checks++; if (rs1_data !== 32'h33) begin n_fail++; $display("FAIL same_data got=%h exp=33", rs1_data); end
  endtask

  task automatic test_mid_reset();
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 32'h5;
    wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'hC;
    tick();
    wb_addr = 5'd13; wb_data = 32'hD;
    tick();
    wb_valid = 1'b0;
    #1;
    n_checks++; if (fifo_level !== 5'd2) begin n_fail++; $display("FAIL mrst_level2 got=%0d exp=2", fifo_level); end
    cfg_we = 1'b0; rst_n = 1'b0;
    #1;
    n_checks++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_wb_ready got=%b exp=0", wb_ready); end
    tick();
    rst_n = 1'b1; rs1_addr = 5'd12; rs2_addr = 5'd5; iss_rd = 5'd3;
    #1;
    n_checks++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL mrst_level got=%0d exp=0", fifo_level); end
    n_checks++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin n_fail++; $display("FAIL mrst_regs got=%h/%h exp=0/0", rs1_data, rs2_data); end
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_busy got=%b exp=1", iss_ready); end
    tick();
    rs2_addr = 5'd13;
    #1;
    n_checks++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || fifo_level !== 5'd0) begin n_fail++; $display("FAIL mrst_no_commit got=%h/%h/%0d exp=0/0/0", rs1_data, rs2_data, fifo_level); end
  endtask

  task automatic test_random();
    bit              held;
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
    held = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      if (!held) begin
        wb_valid = ($urandom_range(0, 2) != 0);
        wb_addr  = AW'($urandom_range(0, 7));
        wb_data  = $urandom;
      end
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = AW'($urandom_range(0, 7));
      cfg_data  = $urandom;
      iss_valid = $urandom_range(0, 1) == 1;
      iss_rd    = AW'($urandom_range(0, 7));
      rs1_addr  = AW'($urandom_range(0, 7));
      rs2_addr  = AW'($urandom_range(0, 31));
      #1;
      e1 = (rs1_addr == 0) ? '0 : m_regs[rs1_addr];
      e2 = (rs2_addr == 0) ? '0 : m_regs[rs2_addr];
      n_checks++; if (rs1_data !== e1) begin n_fail++; $display("FAIL rnd_rs1_data cyc=%0d got=%h exp=%h", cyc, rs1_data, e1); end
      n_checks++; if (rs2_data !== e2) begin n_fail++; $display("FAIL rnd_rs2_data cyc=%0d got=%h exp=%h", cyc, rs2_data, e2); end
      n_checks++; if (rs1_busy !== m_busy[rs1_addr]) begin n_fail++; $display("FAIL rnd_rs1_busy cyc=%0d got=%b exp=%b", cyc, rs1_busy, m_busy[rs1_addr]); end
      n_checks++; if (rs2_busy !== m_busy[rs2_addr]) begin n_fail++; $display("FAIL rnd_rs2_busy cyc=%0d got=%b exp=%b", cyc, rs2_busy, m_busy[rs2_addr]); end
      n_checks++; if (iss_ready !== !m_busy[iss_rd]) begin n_fail++; $display("FAIL rnd_iss_ready cyc=%0d got=%b exp=%b", cyc, iss_ready, !m_busy[iss_rd]); end
      n_checks++; if (wb_ready !== (rst_n && m_q.size() < FIFO_DEPTH)) begin n_fail++; $display("FAIL rnd_wb_ready cyc=%0d got=%b exp=%b", cyc, wb_ready, (rst_n && m_q.size() < FIFO_DEPTH)); end
      n_checks++; if (fifo_level !== AW'(m_q.size())) begin n_fail++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, m_q.size()); end
      held = wb_valid && !(rst_n && m_q.size() < FIFO_DEPTH);
      tick();
    end
    rst_n = 1'b1;
    drive_idle();
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    test_reset();
    test_basic_write();
    test_cfg_priority();
    test_full();
    test_x0();
    test_same_edge();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
